// File: rtl/mintz80_pkg.sv
// mintz80_pkg: shared MinTZ80 I/O port constants, tone FSM states and status bit positions.
package mintz80_pkg;
    localparam logic [7:0] TONE_LO  = 8'hD0;
    localparam logic [7:0] TONE_HI  = 8'hD2;
    localparam logic [7:0] TONE_DUR = 8'hD3;
    localparam int STAT_BUSY = 7;
    localparam int STAT_IRQ  = 6;
    typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} tone_state_e;
endpackage

// File: rtl/mintz80_tone_if.sv
// mintz80_tone_if: Z80 I/O bus slice seen by the tone block; data floats high when nobody drives it.
interface mintz80_tone_if;
    logic       iorq;
    logic       rd;
    logic       wr;
    logic [7:0] a07;
    tri1  [7:0] data;
    logic       int_n;
    modport master (output iorq, rd, wr, a07, input int_n, inout data);
    modport slave  (input iorq, rd, wr, a07, output int_n, inout data);
endinterface

// File: rtl/z80_strobe_sync.sv
// z80_strobe_sync: 2-FF synchronizers for Z80 /IORQ,/RD,/WR with I/O write-start and read-start/end pulses.
module z80_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_iorq,
    input  logic i_rd,
    input  logic i_wr,
    output logic o_wr_start,
    output logic o_rd_start,
    output logic o_rd_end
);
    logic [1:0] r_iorq, r_rd, r_wr;
    logic       r_wr_act, r_rd_act;
    logic       w_wr_act, w_rd_act;
    assign w_wr_act   = !r_iorq[1] && !r_wr[1];
    assign w_rd_act   = !r_iorq[1] && !r_rd[1];
    assign o_wr_start = w_wr_act && !r_wr_act;
    assign o_rd_start = w_rd_act && !r_rd_act;
    assign o_rd_end   = !w_rd_act && r_rd_act;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iorq   <= 2'b11;
            r_rd     <= 2'b11;
            r_wr     <= 2'b11;
            r_wr_act <= 1'b0;
            r_rd_act <= 1'b0;
        end else begin
            r_iorq   <= {r_iorq[0], i_iorq};
            r_rd     <= {r_rd[0], i_rd};
            r_wr     <= {r_wr[0], i_wr};
            r_wr_act <= w_wr_act;
            r_rd_act <= w_rd_act;
        end
    end
endmodule

// File: rtl/mintz80_tone.sv
// mintz80_tone: Z80 I/O-mapped square-wave tone generator with timed duration and completion interrupt.
module mintz80_tone
    import mintz80_pkg::*;
#(
    parameter int TICK_DIV = 40000,
    parameter int TICK_W   = 16
) (
    input  logic          clk,
    input  logic          reset,
    mintz80_tone_if.slave bus,
    output logic          spk,
    output logic          busy
);
    localparam logic [TICK_W-1:0] PRE_LOAD = TICK_W'(TICK_DIV - 1);
    tone_state_e       r_state;
    logic [11:0]       r_div, r_tone;
    logic [TICK_W-1:0] r_pre;
    logic [7:0]        r_dur;
    logic              r_irq_en, r_irq_pend, r_stat_rd, r_spk;
    logic              w_wr_start, w_rd_start, w_rd_end;
    logic              w_wr_lo, w_wr_hi, w_wr_dur, w_tick, w_done, w_stat_sel;
    logic [7:0]        w_status;

    z80_strobe_sync u_sync (
        .clk        (clk),
        .rst_n      (reset),
        .i_iorq     (bus.iorq),
        .i_rd       (bus.rd),
        .i_wr       (bus.wr),
        .o_wr_start (w_wr_start),
        .o_rd_start (w_rd_start),
        .o_rd_end   (w_rd_end)
    );

    assign w_wr_lo    = w_wr_start && bus.a07 == TONE_LO;
    assign w_wr_hi    = w_wr_start && bus.a07 == TONE_HI;
    assign w_wr_dur   = w_wr_start && bus.a07 == TONE_DUR;
    assign w_tick     = r_pre == '0;
    assign w_done     = r_state == ST_PLAY && w_tick && r_dur == 8'd1;
    assign w_stat_sel = reset && !bus.iorq && !bus.rd && bus.a07 == TONE_LO;
    assign busy       = r_state == ST_PLAY;
    assign spk        = r_spk;
    assign bus.int_n  = !(r_irq_pend && r_irq_en);
    assign bus.data   = w_stat_sel ? w_status : 8'hzz;

    always_comb begin
        w_status            = '0;
        w_status[STAT_BUSY] = busy;
        w_status[STAT_IRQ]  = r_irq_pend;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_tone     <= '0;
            r_pre      <= '0;
            r_dur      <= '0;
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_stat_rd  <= 1'b0;
            r_spk      <= 1'b0;
        end else begin
            if (w_wr_lo)
                r_div[7:0] <= bus.data;
            if (w_wr_hi) begin
                r_div[11:8] <= bus.data[3:0];
                r_irq_en    <= bus.data[7];
            end
            // the address may be gone by the time the read end is synchronized, so remember the match
            if (w_rd_start)
                r_stat_rd <= bus.a07 == TONE_LO;
            else if (w_rd_end)
                r_stat_rd <= 1'b0;
            if (w_rd_end && r_stat_rd)
                r_irq_pend <= 1'b0;
            if (w_wr_dur) begin
                r_state <= bus.data == 8'd0 ? ST_IDLE : ST_PLAY;
                r_tone  <= r_div;
                r_pre   <= PRE_LOAD;
                r_dur   <= bus.data;
                if (bus.data == 8'd0)
                    r_spk <= 1'b0;
            end else if (r_state == ST_PLAY) begin
                r_tone <= r_tone == 12'd0 ? r_div : r_tone - 12'd1;
                r_pre  <= w_tick ? PRE_LOAD : r_pre - TICK_W'(1);
                if (w_tick)
                    r_dur <= r_dur - 8'd1;
                if (r_tone == 12'd0)
                    r_spk <= r_div != 12'd0 && !r_spk;
                if (w_done) begin
                    r_state    <= ST_IDLE;
                    r_spk      <= 1'b0;
                    r_irq_pend <= 1'b1;
                end
            end
        end
    end
endmodule
